immediate_extender_pipe: RTL and testbench

Registered, parametrised immediate extender for the Galetron decode stage. It takes the three instruction immediate fields (A, B, C), selects one, and sign- or zero-extends it to the datapath width. It adds a two-beat "pair" mode that concatenates two A fields into one wide immediate. Results leave through a one-deep valid/ready output register that feeds the ALU operand mux.

---
 rtl/immediate_extender_pipe.sv | 151 +++++++++++++++
 tb/tb_immediate_extender_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/immediate_extender_pipe.sv
// Purpose: select immediate field A/B/C (or an A:A pair) and sign/zero-extend it to DATA_WIDTH.
// Latency: one cycle; a beat accepted at edge N is visible on extenderOutput after edge N.
// Backpressure: one-deep output register; inReady = !outValid || outReady (accept and drain may overlap).
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   inValid / inReady     input beat handshake
//   extenderSelection     00=A, 01=B, 10=C, 11=pair (two A beats concatenated)
//   signMode              1=sign-extend, 0=zero-extend
//   inputA/B/C            immediate fields
//   outValid / outReady   result handshake
//   extenderOutput        extended immediate
//   pairPending           first half of a pair has been captured
//
// Build option: define EXTENDER_PAIR_EN to implement the two-beat pair mode.
// Without it, selection 11 produces the constant 1 in a single beat and
// pairPending is tied low.

module immediate_extender_pipe #(
  parameter int DATA_WIDTH    = 32,
  parameter int FIELD_A_WIDTH = 16,
  parameter int FIELD_B_WIDTH = 21,
  parameter int FIELD_C_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [1:0]               extenderSelection,
  input  logic                     signMode,
  input  logic [FIELD_A_WIDTH-1:0] inputA,
  input  logic [FIELD_B_WIDTH-1:0] inputB,
  input  logic [FIELD_C_WIDTH-1:0] inputC,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [DATA_WIDTH-1:0]    extenderOutput,
  output logic                     pairPending
);

  logic                  accept;
  logic                  loadResult;
  logic [DATA_WIDTH-1:0] resultNext;
  logic [DATA_WIDTH-1:0] extA;
  logic [DATA_WIDTH-1:0] extB;
  logic [DATA_WIDTH-1:0] extC;
  logic [DATA_WIDTH-1:0] singleResult;

  assign inReady = !outValid || outReady;
  assign accept  = inValid && inReady;

  // Width casts of a signed operand replicate the MSB; of an unsigned
  // operand they pad with zeros. This also covers the zero-replication case
  // where a pair exactly fills DATA_WIDTH.
  assign extA = signMode ? DATA_WIDTH'($signed(inputA)) : DATA_WIDTH'(inputA);
  assign extB = signMode ? DATA_WIDTH'($signed(inputB)) : DATA_WIDTH'(inputB);
  assign extC = signMode ? DATA_WIDTH'($signed(inputC)) : DATA_WIDTH'(inputC);

  // Selection 11 only reaches this mux as a real result when pair mode is
  // not built; with pair mode the FSM steers 11 away from it.
  always_comb begin
    singleResult = DATA_WIDTH'(1);
    case (extenderSelection)
      2'b00:   singleResult = extA;
      2'b01:   singleResult = extB;
      2'b10:   singleResult = extC;
      default: singleResult = DATA_WIDTH'(1);
    endcase
  end

`ifdef EXTENDER_PAIR_EN

  typedef enum logic {
    IDLE      = 1'b0,
    PAIR_WAIT = 1'b1
  } pairState_t;

  pairState_t                 state;
  pairState_t                 stateNext;
  logic                       loadHigh;
  logic [FIELD_A_WIDTH-1:0]   highReg;
  logic [2*FIELD_A_WIDTH-1:0] pairWord;
  logic [DATA_WIDTH-1:0]      pairResult;

  assign pairWord   = {highReg, inputA};
  assign pairResult = signMode ? DATA_WIDTH'($signed(pairWord)) : DATA_WIDTH'(pairWord);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      highReg <= '0;
    end else begin
      state <= stateNext;
      if (loadHigh) begin
        highReg <= inputA;
      end
    end
  end

  // The second pair beat ignores its selection and B/C fields entirely.
  always_comb begin
    stateNext  = state;
    loadHigh   = 1'b0;
    loadResult = 1'b0;
    resultNext = singleResult;
    case (state)
      IDLE: begin
        if (accept) begin
          if (extenderSelection == 2'b11) begin
            loadHigh  = 1'b1;
            stateNext = PAIR_WAIT;
          end else begin
            loadResult = 1'b1;
          end
        end
      end
      PAIR_WAIT: begin
        if (accept) begin
          loadResult = 1'b1;
          resultNext = pairResult;
          stateNext  = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign pairPending = (state == PAIR_WAIT);

`else

  assign loadResult  = accept;
  assign resultNext  = singleResult;
  assign pairPending = 1'b0;

`endif

  // Output register: a new load wins over a drain, so accept-and-drain in
  // the same cycle keeps outValid high with the fresh value.
  always_ff @(posedge clock) begin
    if (reset) begin
      outValid       <= 1'b0;
      extenderOutput <= '0;
    end else if (loadResult) begin
      outValid       <= 1'b1;
      extenderOutput <= resultNext;
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_immediate_extender_pipe.sv
module tb_immediate_extender_pipe;

  localparam int DW = 32;
  localparam int FA = 16;
  localparam int FB = 21;
  localparam int FC = 16;

`ifdef EXTENDER_PAIR_EN
  localparam bit PAIR_EN = 1'b1;
`else
  localparam bit PAIR_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          inValid;
  logic          inReady;
  logic [1:0]    extenderSelection;
  logic          signMode;
  logic [FA-1:0] inputA;
  logic [FB-1:0] inputB;
  logic [FC-1:0] inputC;
  logic          outValid;
  logic          outReady;
  logic [DW-1:0] extenderOutput;
  logic          pairPending;

  int passCount  = 0;
  int checkCount = 0;

  immediate_extender_pipe #(
    .DATA_WIDTH   (DW),
    .FIELD_A_WIDTH(FA),
    .FIELD_B_WIDTH(FB),
    .FIELD_C_WIDTH(FC)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .inValid          (inValid),
    .inReady          (inReady),
    .extenderSelection(extenderSelection),
    .signMode         (signMode),
    .inputA           (inputA),
    .inputB           (inputB),
    .inputC           (inputC),
    .outValid         (outValid),
    .outReady         (outReady),
    .extenderOutput   (extenderOutput),
    .pairPending      (pairPending)
  );

  always #5 clock = ~clock;

  // Reference: a w-bit value extended to 32 bits with plain arithmetic.
  function automatic logic [DW-1:0] refExtend(longint unsigned v, int w, bit s);
    longint unsigned mask;
    mask = (64'd1 << w) - 64'd1;
    v    = v & mask;
    if (s && (((v >> (w - 1)) & 64'd1) == 64'd1)) v = v | ~mask;
    return v[DW-1:0];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setBeat(input logic [1:0] sel, input logic s, input logic [FA-1:0] a,
                         input logic [FB-1:0] b, input logic [FC-1:0] c);
    inValid           = 1'b1;
    extenderSelection = sel;
    signMode          = s;
    inputA            = a;
    inputB            = b;
    inputC            = c;
  endtask

  task automatic test_reset();
    reset = 1'b1; inValid = 1'b0; outReady = 1'b1;
    extenderSelection = 2'b00; signMode = 1'b0; inputA = '0; inputB = '0; inputC = '0;
    tick(); tick();
    // beat offered while reset is high must be dropped
    setBeat(2'b00, 1'b0, 16'h00AA, '0, '0);
    tick();
    inValid = 1'b0;
    reset   = 1'b0;
    #1;
    checkCount++; if (outValid !== 1'b0) $display("FAIL reset_outValid got=%b exp=0", outValid); else passCount++;
    checkCount++; if (extenderOutput !== 32'h0) $display("FAIL reset_output got=%h exp=00000000", extenderOutput); else passCount++;
    checkCount++; if (pairPending !== 1'b0) $display("FAIL reset_pairPending got=%b exp=0", pairPending); else passCount++;
    checkCount++; if (inReady !== 1'b1) $display("FAIL reset_inReady got=%b exp=1", inReady); else passCount++;
    tick();
    checkCount++; if (outValid !== 1'b0) $display("FAIL reset_beat_dropped got=%b exp=0", outValid); else passCount++;
  endtask

  task automatic test_single_fields();
    logic [1:0]    sels [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
    logic          sgns [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [DW-1:0] exps [4] = '{32'hFFFF8001, 32'h00008001, 32'hFFF00000, 32'h00007FFF};
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      setBeat(sels[i], sgns[i], 16'h8001, 21'h100000, 16'h7FFF);
      tick();
      checkCount++; if (outValid !== 1'b1) $display("FAIL single_valid[%0d] got=%b exp=1", i, outValid); else passCount++;
      checkCount++; if (extenderOutput !== exps[i]) $display("FAIL single_value[%0d] got=%h exp=%h", i, extenderOutput, exps[i]); else passCount++;
    end
    inValid = 1'b0;
    tick();
    checkCount++; if (outValid !== 1'b0) $display("FAIL single_drain got=%b exp=0", outValid); else passCount++;
  endtask

  task automatic test_pair();
    outReady = 1'b1;
    setBeat(2'b11, 1'b1, 16'hDEAD, 21'h1ABCD, 16'h5555);
    tick();
    if (PAIR_EN) begin
      checkCount++; if (outValid !== 1'b0) $display("FAIL pair_first_no_output got=%b exp=0", outValid); else passCount++;
      checkCount++; if (pairPending !== 1'b1) $display("FAIL pair_pending_set got=%b exp=1", pairPending); else passCount++;
      // second beat: selection and B/C must be ignored
      setBeat(2'b01, 1'b1, 16'hBEEF, 21'h00123, 16'h0042);
      tick();
      checkCount++; if (outValid !== 1'b1) $display("FAIL pair_valid got=%b exp=1", outValid); else passCount++;
      checkCount++; if (extenderOutput !== 32'hDEADBEEF) $display("FAIL pair_value got=%h exp=DEADBEEF", extenderOutput); else passCount++;
      checkCount++; if (pairPending !== 1'b0) $display("FAIL pair_pending_clear got=%b exp=0", pairPending); else passCount++;
    end else begin
      checkCount++; if (outValid !== 1'b1) $display("FAIL sel11_valid got=%b exp=1", outValid); else passCount++;
      checkCount++; if (extenderOutput !== 32'h00000001) $display("FAIL sel11_value got=%h exp=00000001", extenderOutput); else passCount++;
      checkCount++; if (pairPending !== 1'b0) $display("FAIL sel11_pending got=%b exp=0", pairPending); else passCount++;
    end
    inValid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    outReady = 1'b1;
    setBeat(2'b00, 1'b0, 16'h0005, '0, '0);
    tick();
    outReady = 1'b0;
    setBeat(2'b00, 1'b0, 16'h0007, '0, '0);
    #1;
    checkCount++; if (inReady !== 1'b0) $display("FAIL bp_inReady_low got=%b exp=0", inReady); else passCount++;
    tick();
    checkCount++; if (extenderOutput !== 32'h5) $display("FAIL bp_hold got=%h exp=00000005", extenderOutput); else passCount++;
    checkCount++; if (outValid !== 1'b1) $display("FAIL bp_hold_valid got=%b exp=1", outValid); else passCount++;
    outReady = 1'b1;
    #1;
    checkCount++; if (inReady !== 1'b1) $display("FAIL bp_inReady_high got=%b exp=1", inReady); else passCount++;
    tick();
    inValid = 1'b0;
    checkCount++; if (extenderOutput !== 32'h7) $display("FAIL bp_next_value got=%h exp=00000007", extenderOutput); else passCount++;
    checkCount++; if (outValid !== 1'b1) $display("FAIL bp_next_valid got=%b exp=1", outValid); else passCount++;
    tick();
    checkCount++; if (outValid !== 1'b0) $display("FAIL bp_final_drain got=%b exp=0", outValid); else passCount++;
  endtask

  task automatic test_reset_mid_pair();
    outReady = 1'b1;
    setBeat(2'b11, 1'b1, 16'h1234, '0, '0);
    tick();
    inValid = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    checkCount++; if (pairPending !== 1'b0) $display("FAIL midpair_pending got=%b exp=0", pairPending); else passCount++;
    checkCount++; if (outValid !== 1'b0) $display("FAIL midpair_valid got=%b exp=0", outValid); else passCount++;
    setBeat(2'b00, 1'b0, 16'h0002, '0, '0);
    tick();
    inValid = 1'b0;
    checkCount++; if (extenderOutput !== 32'h2) $display("FAIL midpair_next got=%h exp=00000002", extenderOutput); else passCount++;
    checkCount++; if (outValid !== 1'b1) $display("FAIL midpair_next_valid got=%b exp=1", outValid); else passCount++;
    tick();
  endtask

  task automatic test_streaming();
    outReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      setBeat(2'b00, 1'b0, FA'(i), '0, '0);
      #1;
      checkCount++; if (inReady !== 1'b1) $display("FAIL stream_ready[%0d] got=%b exp=1", i, inReady); else passCount++;
      tick();
      checkCount++; if (outValid !== 1'b1 || extenderOutput !== 32'(i))
        $display("FAIL stream_result[%0d] got=%b/%h exp=1/%h", i, outValid, extenderOutput, 32'(i)); else passCount++;
    end
    inValid = 1'b0;
    tick();
  endtask

  // Random traffic against a transaction-level model of the pipe.
  task automatic test_random();
    bit            mValid = 1'b0;
    bit            mPend  = 1'b0;
    logic [DW-1:0] mData  = '0;
    logic [FA-1:0] mHigh  = '0;
    bit            expReady;
    bit            acc;
    bit            produce;
    logic [DW-1:0] res;
    reset = 1'b1; inValid = 1'b0;
    tick();
    reset = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      setBeat(2'($urandom_range(0, 3)), 1'($urandom), FA'($urandom), FB'($urandom), FC'($urandom));
      inValid  = ($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 2) != 0);
      #1;
      expReady = !mValid || outReady;
      checkCount++; if (inReady !== expReady) $display("FAIL rand_inReady[%0d] got=%b exp=%b", cyc, inReady, expReady); else passCount++;
      acc     = inValid && expReady;
      produce = 1'b0;
      res     = '0;
      if (acc) begin
        if (PAIR_EN && mPend) begin
          res = refExtend((longint'(mHigh) << FA) + longint'(inputA), 2 * FA, signMode);
          produce = 1'b1; mPend = 1'b0;
        end else if (extenderSelection == 2'b11) begin
          if (PAIR_EN) begin mPend = 1'b1; mHigh = inputA; end
          else begin res = 32'd1; produce = 1'b1; end
        end else begin
          case (extenderSelection)
            2'b00:   res = refExtend(longint'(inputA), FA, signMode);
            2'b01:   res = refExtend(longint'(inputB), FB, signMode);
            default: res = refExtend(longint'(inputC), FC, signMode);
          endcase
          produce = 1'b1;
        end
      end
      if (produce) begin mValid = 1'b1; mData = res; end
      else if (outReady) mValid = 1'b0;
      tick();
      checkCount++; if (outValid !== mValid) $display("FAIL rand_outValid[%0d] got=%b exp=%b", cyc, outValid, mValid); else passCount++;
      checkCount++; if (pairPending !== mPend) $display("FAIL rand_pairPending[%0d] got=%b exp=%b", cyc, pairPending, mPend); else passCount++;
      if (mValid) begin
        checkCount++; if (extenderOutput !== mData) $display("FAIL rand_output[%0d] got=%h exp=%h", cyc, extenderOutput, mData); else passCount++;
      end
    end
    inValid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fields();
    test_pair();
    test_backpressure();
    test_reset_mid_pair();
    test_streaming();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
